// File: rtl/cache_ctrl.sv
// rtl/cache_ctrl.sv - direct-mapped cache controller with write-back, line fill and perf counters
module cache_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [15:0]      cpu_addr,
  input  logic             cpu_rd,
  input  logic             cpu_wr,
  input  logic [15:0]      cpu_wdata,
  output logic [15:0]      cpu_rdata,
  output logic             cpu_stall,
  output logic [13:0]      c_addr,
  output logic             c_re,
  output logic             c_we,
  output logic [63:0]      c_wr_data,
  output logic             c_wdirty,
  input  logic [63:0]      c_rd_data,
  input  logic [7:0]       c_tag_out,
  input  logic             c_hit,
  input  logic             c_dirty,
  output logic [13:0]      m_addr,
  output logic             m_re,
  output logic             m_we,
  output logic [63:0]      m_wr_data,
  input  logic [63:0]      m_rd_data,
  input  logic             m_rdy,
  output logic [CNT_W-1:0] hit_cnt,
  output logic [CNT_W-1:0] miss_cnt
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] EVICT   = 2'd1;
  localparam logic [1:0] FILL    = 2'd2;
  localparam logic [1:0] INSTALL = 2'd3;

  logic [1:0]  state;
  logic [1:0]  next_state;
  logic [63:0] victim_data;
  logic [7:0]  victim_tag;
  logic [63:0] fill_data;
  logic        relookup;
  logic        req;
  logic        lookup;
  logic        hit;
  logic        miss;

  function automatic logic [63:0] merge_word(input logic [63:0] line, input logic [1:0] sel,
                                             input logic [15:0] data);
    logic [63:0] r;
    r = line;
    r[{sel, 4'b0000} +: 16] = data;
    return r;
  endfunction

  // Strobes are gated by rst_n so they drop the instant reset asserts.
  assign req    = cpu_rd | cpu_wr;
  assign lookup = rst_n && (state == IDLE) && req;
  assign hit    = lookup && c_hit;
  assign miss   = lookup && !c_hit;

  assign c_addr    = cpu_addr[15:2];
  assign c_re      = lookup;
  assign c_we      = (hit && cpu_wr) || (rst_n && (state == INSTALL));
  assign c_wdirty  = cpu_wr;
  assign c_wr_data = (state == INSTALL)
                     ? (cpu_wr ? merge_word(fill_data, cpu_addr[1:0], cpu_wdata) : fill_data)
                     : merge_word(c_rd_data, cpu_addr[1:0], cpu_wdata);
  assign cpu_rdata = (hit && !cpu_wr) ? c_rd_data[{cpu_addr[1:0], 4'b0000} +: 16] : 16'h0000;
  assign cpu_stall = rst_n && (miss || (state != IDLE));

  assign m_we      = rst_n && (state == EVICT);
  assign m_re      = rst_n && (state == FILL);
  assign m_addr    = (state == EVICT) ? {victim_tag, cpu_addr[7:2]} : cpu_addr[15:2];
  assign m_wr_data = victim_data;

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (miss) next_state = c_dirty ? EVICT : FILL;
      EVICT:   if (m_rdy) next_state = FILL;
      FILL:    if (m_rdy) next_state = INSTALL;
      INSTALL: next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      victim_data <= '0;
      victim_tag  <= '0;
      fill_data   <= '0;
      relookup    <= 1'b0;
      hit_cnt     <= '0;
      miss_cnt    <= '0;
    end else begin
      state    <= next_state;
      // The lookup right after INSTALL is the same access; it must not count as a hit.
      relookup <= (state == INSTALL);
      if (miss) begin
        victim_data <= c_rd_data;
        victim_tag  <= c_tag_out;
      end
      if ((state == FILL) && m_rdy)
        fill_data <= m_rd_data;
      if (hit && !relookup && (hit_cnt != {CNT_W{1'b1}}))
        hit_cnt <= hit_cnt + 1'b1;
      if (miss && (miss_cnt != {CNT_W{1'b1}}))
        miss_cnt <= miss_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_cache_ctrl.sv
// tb/tb_cache_ctrl.sv - randomized self-checking bench for cache_ctrl against a line-level cache model
module tb_cache_ctrl;

  logic        clk;
  logic        rst_n;
  logic [15:0] cpu_addr;
  logic        cpu_rd;
  logic        cpu_wr;
  logic [15:0] cpu_wdata;
  logic [15:0] cpu_rdata;
  logic        cpu_stall;
  logic [13:0] c_addr;
  logic        c_re;
  logic        c_we;
  logic [63:0] c_wr_data;
  logic        c_wdirty;
  logic [63:0] c_rd_data;
  logic [7:0]  c_tag_out;
  logic        c_hit;
  logic        c_dirty;
  logic [13:0] m_addr;
  logic        m_re;
  logic        m_we;
  logic [63:0] m_wr_data;
  logic [63:0] m_rd_data;
  logic        m_rdy;
  logic [15:0] hit_cnt;
  logic [15:0] miss_cnt;

  logic [15:0] s_rdata;
  logic        s_stall;
  logic [13:0] s_c_addr;
  logic        s_c_re;
  logic        s_c_we;
  logic [63:0] s_c_wr_data;
  logic        s_c_wdirty;
  logic [13:0] s_m_addr;
  logic        s_m_re;
  logic        s_m_we;
  logic [63:0] s_m_wr_data;
  logic [1:0]  s_hit_cnt;
  logic [1:0]  s_miss_cnt;

  int vectors = 0;
  int errors  = 0;

  cache_ctrl #(.CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .cpu_addr(cpu_addr), .cpu_rd(cpu_rd), .cpu_wr(cpu_wr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .c_addr(c_addr), .c_re(c_re), .c_we(c_we), .c_wr_data(c_wr_data), .c_wdirty(c_wdirty),
    .c_rd_data(c_rd_data), .c_tag_out(c_tag_out), .c_hit(c_hit), .c_dirty(c_dirty),
    .m_addr(m_addr), .m_re(m_re), .m_we(m_we), .m_wr_data(m_wr_data),
    .m_rd_data(m_rd_data), .m_rdy(m_rdy), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  // Narrow-counter twin sees identical stimulus so its counters reach saturation quickly.
  cache_ctrl #(.CNT_W(2)) u_sat (
    .clk(clk), .rst_n(rst_n), .cpu_addr(cpu_addr), .cpu_rd(cpu_rd), .cpu_wr(cpu_wr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(s_rdata), .cpu_stall(s_stall),
    .c_addr(s_c_addr), .c_re(s_c_re), .c_we(s_c_we), .c_wr_data(s_c_wr_data), .c_wdirty(s_c_wdirty),
    .c_rd_data(c_rd_data), .c_tag_out(c_tag_out), .c_hit(c_hit), .c_dirty(c_dirty),
    .m_addr(s_m_addr), .m_re(s_m_re), .m_we(s_m_we), .m_wr_data(s_m_wr_data),
    .m_rd_data(m_rd_data), .m_rdy(m_rdy), .hit_cnt(s_hit_cnt), .miss_cnt(s_miss_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Cache data array
  bit          arr_clr;
  bit          arr_valid [64];
  bit          arr_dirty [64];
  logic [7:0]  arr_tag   [64];
  logic [63:0] arr_data  [64];

  always_comb begin
    c_rd_data = arr_data[c_addr[5:0]];
    c_tag_out = arr_tag[c_addr[5:0]];
    c_hit     = arr_valid[c_addr[5:0]] && (arr_tag[c_addr[5:0]] == c_addr[13:6]);
    c_dirty   = arr_valid[c_addr[5:0]] && arr_dirty[c_addr[5:0]];
  end

  always @(posedge clk) begin
    if (arr_clr) begin
      for (int i = 0; i < 64; i++) begin
        arr_valid[i] <= 1'b0;
        arr_dirty[i] <= 1'b0;
        arr_tag[i]   <= 8'h00;
        arr_data[i]  <= 64'h0;
      end
    end else if (c_we) begin
      arr_data[c_addr[5:0]]  <= c_wr_data;
      arr_tag[c_addr[5:0]]   <= c_addr[13:6];
      arr_valid[c_addr[5:0]] <= 1'b1;
      arr_dirty[c_addr[5:0]] <= c_wdirty;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] init_line(input logic [13:0] a);
    logic [15:0] x;
    x = {2'b00, a};
    return {x * 16'd3 + 16'd1, x ^ 16'h5a5a, x + 16'h1234, ~x};
  endfunction

  function automatic logic [63:0] put_word(input logic [63:0] line, input logic [1:0] sel,
                                           input logic [15:0] d);
    logic [63:0] r;
    r = line;
    r[{sel, 4'b0000} +: 16] = d;
    return r;
  endfunction

  function automatic logic [15:0] get_word(input logic [63:0] line, input logic [1:0] sel);
    return line[{sel, 4'b0000} +: 16];
  endfunction

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  // Unified memory responder
  logic [63:0] mem [logic [13:0]];
  int          mem_lat = 1;
  int          wcnt = 0;
  logic [13:0] ev_addr_q [$];
  logic [63:0] ev_data_q [$];
  logic [13:0] fill_q    [$];

  initial begin
    m_rdy     = 1'b0;
    m_rd_data = 64'h0;
    forever begin
      @(negedge clk);
      if (!rst_n || !(m_re || m_we)) begin
        m_rdy = 1'b0;
        wcnt  = 0;
      end else if (m_rdy) begin
        m_rdy = 1'b0;
        wcnt  = 0;
      end else begin
        check("mem_strobe_overlap", {63'b0, m_re & m_we}, 64'h0);
        wcnt++;
        if (wcnt >= mem_lat) begin
          m_rdy = 1'b1;
          if (m_we) begin
            mem[m_addr] = m_wr_data;
            ev_addr_q.push_back(m_addr);
            ev_data_q.push_back(m_wr_data);
          end else begin
            m_rd_data = mem.exists(m_addr) ? mem[m_addr] : init_line(m_addr);
            fill_q.push_back(m_addr);
          end
        end
      end
    end
  end

  // Reference model: line-granular tag store plus the architecturally current value of every line
  bit          mvalid [64];
  bit          mdirty [64];
  logic [7:0]  mtag   [64];
  logic [63:0] gline  [logic [13:0]];
  int          exp_hit  = 0;
  int          exp_miss = 0;
  logic [63:0] obs_line;
  logic [63:0] obs_install;

  function automatic logic [63:0] gget(input logic [13:0] a);
    return gline.exists(a) ? gline[a] : init_line(a);
  endfunction

  task automatic do_access(input logic [15:0] a, input logic rd, input logic wr,
                           input logic [15:0] wd, input int lat);
    logic [5:0]  idx;
    logic [7:0]  tg;
    logic [13:0] la;
    logic        hit_e;
    logic        ev_e;
    logic [13:0] ev_a;
    logic [63:0] ev_d;
    logic [63:0] line_old;
    logic [63:0] line_new;
    int          n;
    int          installs;
    idx      = a[7:2];
    tg       = a[15:8];
    la       = a[15:2];
    hit_e    = mvalid[idx] && (mtag[idx] == tg);
    ev_e     = !hit_e && mvalid[idx] && mdirty[idx];
    ev_a     = {mtag[idx], idx};
    ev_d     = gget(ev_a);
    line_old = gget(la);
    line_new = wr ? put_word(line_old, a[1:0], wd) : line_old;
    mem_lat  = lat;
    ev_addr_q.delete();
    ev_data_q.delete();
    fill_q.delete();

    @(negedge clk);
    cpu_addr  = a;
    cpu_rd    = rd;
    cpu_wr    = wr;
    cpu_wdata = wd;
    #1;
    check("first_stall", {63'b0, cpu_stall}, {63'b0, !hit_e});
    check("sat_twin_mirror",
          {63'b0, {s_rdata, s_stall, s_c_addr, s_c_re, s_c_we, s_c_wr_data, s_c_wdirty,
                   s_m_addr, s_m_re, s_m_we, s_m_wr_data} ===
                  {cpu_rdata, cpu_stall, c_addr, c_re, c_we, c_wr_data, c_wdirty,
                   m_addr, m_re, m_we, m_wr_data}}, 64'h1);
    if (!hit_e) begin
      n = 0;
      installs = 0;
      while (cpu_stall && n < 60) begin
        @(negedge clk);
        #1;
        n++;
        if (cpu_stall && c_we) begin
          installs++;
          obs_install = c_wr_data;
          check("install_line", c_wr_data, line_new);
          check("install_wdirty", {63'b0, c_wdirty}, {63'b0, wr});
        end
      end
      check("miss_completes", {63'b0, cpu_stall}, 64'h0);
      check("install_count", installs, 1);
      check("evict_count", ev_addr_q.size(), ev_e ? 1 : 0);
      if (ev_e && ev_addr_q.size() == 1) begin
        check("evict_addr", {50'b0, ev_addr_q[0]}, {50'b0, ev_a});
        check("evict_data", ev_data_q[0], ev_d);
      end
      check("fill_count", fill_q.size(), 1);
      if (fill_q.size() == 1)
        check("fill_addr", {50'b0, fill_q[0]}, {50'b0, la});
    end
    if (!wr) begin
      check("rdata", {48'b0, cpu_rdata}, {48'b0, get_word(line_old, a[1:0])});
    end else begin
      check("hit_we", {63'b0, c_we}, 64'h1);
      check("hit_wr_data", c_wr_data, line_new);
      check("hit_wdirty", {63'b0, c_wdirty}, 64'h1);
    end
    obs_line = c_wr_data;
    @(posedge clk);
    #1;
    cpu_rd = 1'b0;
    cpu_wr = 1'b0;

    if (hit_e) exp_hit++;
    else       exp_miss++;
    if (!hit_e) begin
      mtag[idx]   = tg;
      mvalid[idx] = 1'b1;
      mdirty[idx] = 1'b0;
    end
    if (wr) begin
      gline[la]   = line_new;
      mdirty[idx] = 1'b1;
    end
    check("hit_cnt", {48'b0, hit_cnt}, sat(exp_hit, 65535));
    check("miss_cnt", {48'b0, miss_cnt}, sat(exp_miss, 65535));
    check("sat_hit_cnt", {62'b0, s_hit_cnt}, sat(exp_hit, 3));
    check("sat_miss_cnt", {62'b0, s_miss_cnt}, sat(exp_miss, 3));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, observed running expected done");
    $fatal(1);
  end

  initial begin
    int          n;
    logic [15:0] a;
    int          op;
    rst_n     = 1'b0;
    arr_clr   = 1'b1;
    cpu_addr  = 16'h0000;
    cpu_rd    = 1'b0;
    cpu_wr    = 1'b0;
    cpu_wdata = 16'h0000;
    for (int i = 0; i < 64; i++) begin
      mvalid[i] = 1'b0;
      mdirty[i] = 1'b0;
      mtag[i]   = 8'h00;
    end
    mem[14'h0010]   = 64'h4444_3333_2222_1111;
    gline[14'h0010] = 64'h4444_3333_2222_1111;
    mem[14'h0820]   = 64'h0;
    gline[14'h0820] = 64'h0;

    repeat (3) @(negedge clk);
    #1;
    check("rst_stall", {63'b0, cpu_stall}, 64'h0);
    check("rst_strobes", {60'b0, c_re, c_we, m_re, m_we}, 64'h0);
    check("rst_rdata", {48'b0, cpu_rdata}, 64'h0);
    check("rst_hit_cnt", {48'b0, hit_cnt}, 64'h0);
    check("rst_miss_cnt", {48'b0, miss_cnt}, 64'h0);
    @(negedge clk);
    arr_clr = 1'b0;
    rst_n   = 1'b1;

    do_access(16'h0040, 1'b1, 1'b0, 16'h0000, 3);
    do_access(16'h0041, 1'b0, 1'b1, 16'hBEEF, 2);
    check("plan_write_line", obs_line, 64'h4444_3333_BEEF_1111);
    do_access(16'h1040, 1'b1, 1'b0, 16'h0000, 2);
    do_access(16'h2083, 1'b0, 1'b1, 16'h1234, 2);
    check("plan_install_line", obs_install, 64'h1234_0000_0000_0000);

    // Reset in the middle of a fill aborts the access
    mem_lat = 40;
    @(negedge clk);
    cpu_addr = 16'h3000;
    cpu_rd   = 1'b1;
    cpu_wr   = 1'b0;
    n = 0;
    while (!m_re && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("fill_reached", {63'b0, m_re}, 64'h1);
    #2;
    rst_n = 1'b0;
    #1;
    check("midfill_rst_strobes", {60'b0, c_re, c_we, m_re, m_we}, 64'h0);
    check("midfill_rst_stall", {63'b0, cpu_stall}, 64'h0);
    check("midfill_rst_cnts", {32'b0, hit_cnt, miss_cnt}, 64'h0);
    cpu_rd = 1'b0;
    @(negedge clk);
    rst_n    = 1'b1;
    exp_hit  = 0;
    exp_miss = 0;
    do_access(16'h3000, 1'b1, 1'b0, 16'h0000, 2);

    // Random traffic over a few heavily conflicting lines
    for (int i = 0; i < 200; i++) begin
      a  = {6'b0, 2'($urandom_range(0, 3)), 4'b0, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
      op = $urandom_range(0, 3);
      if ($urandom_range(0, 3) == 0)
        repeat ($urandom_range(1, 3)) @(negedge clk);
      do_access(a, op != 2, op >= 2, 16'($urandom), $urandom_range(1, 4));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
